// File: rtl/c6502_dma_arbiter.sv
// Memory-port arbiter for the c6502: forwards CPU cycles to memory, and on a write to DMA_REG
// stalls the CPU while it copies one page of main memory into the 256-byte destination RAM.
module c6502_dma_arbiter #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter int unsigned LEN     = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce_in,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_in,
  output logic        cpu_ce,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  dst_address,
  output logic [7:0]  dst_data,
  output logic        dst_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  localparam logic [8:0] LastCnt = 9'(LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buf_q, buf_d;
  logic [8:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       hit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      buf_q   <= 8'h00;
      cnt_q   <= 9'd0;
      done_q  <= 1'b0;
    end else if (ce_in) begin
      state_q <= state_d;
      page_q  <= page_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    hit         = cpu_we & (cpu_address == DMA_REG);
    cpu_ce      = 1'b0;
    busy        = 1'b1;
    mem_address = {page_q, cnt_q[7:0]};
    mem_wdata   = cpu_out;
    mem_we      = 1'b0;
    mem_rd      = 1'b0;
    dst_address = 8'h00;
    dst_data    = 8'h00;
    dst_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cpu_ce      = ce_in;
        busy        = 1'b0;
        mem_address = cpu_address;
        mem_we      = cpu_we & ~hit;
        mem_rd      = cpu_rd;
        if (hit) begin
          page_d  = cpu_out;
          cnt_d   = 9'd0;
          state_d = StRd;
        end
      end
      StRd: begin
        mem_rd  = 1'b1;
        buf_d   = mem_rdata;
        state_d = StWr;
      end
      StWr: begin
        dst_address = cnt_q[7:0];
        dst_data    = buf_q;
        // A reset asserted mid-write must not let the byte land.
        dst_we      = ce_in & reset_n;
        if (cnt_q == LastCnt) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          state_d = StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_in = mem_rdata;
  assign done   = done_q;

endmodule

// File: tb/tb_c6502_dma_arbiter.sv
// Directed bench: instance A (LEN=4) covers passthrough, trigger, ce gating and reset abort;
// instance B (LEN=256) covers a full page copy from 0xFF00.
module tb_c6502_dma_arbiter;

  logic        clock = 1'b0;
  logic        reset_n, ce_in, cpu_we_a, cpu_we_b, cpu_rd;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;

  logic [7:0]  cpu_in_a, mem_wdata_a, mem_rdata_a, dst_address_a, dst_data_a;
  logic [15:0] mem_address_a;
  logic        cpu_ce_a, mem_we_a, mem_rd_a, dst_we_a, busy_a, done_a;
  logic [7:0]  cpu_in_b, mem_wdata_b, mem_rdata_b, dst_address_b, dst_data_b;
  logic [15:0] mem_address_b;
  logic        cpu_ce_b, mem_we_b, mem_rd_b, dst_we_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Instance A memory: page 0x02 holds 11,22,33,44; 0x4014 reads back 0x77.
  function automatic logic [7:0] mem_a_fn(input logic [15:0] a);
    case (a)
      16'h0200: return 8'h11;
      16'h0201: return 8'h22;
      16'h0202: return 8'h33;
      16'h0203: return 8'h44;
      16'h4014: return 8'h77;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] src_a(input int i);
    logic [15:0] a;
    a = 16'h0200 + 16'(i);
    return mem_a_fn(a);
  endfunction

  // Instance B memory depends on both address bytes so a wrong page yields wrong data.
  assign mem_rdata_a = mem_a_fn(mem_address_a);
  assign mem_rdata_b = mem_address_b[7:0] ^ mem_address_b[15:8] ^ 8'h5A;

  c6502_dma_arbiter #(.DMA_REG(16'h4014), .LEN(4)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .ce_in(ce_in),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we_a), .cpu_rd(cpu_rd),
    .cpu_in(cpu_in_a), .cpu_ce(cpu_ce_a),
    .mem_address(mem_address_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rd(mem_rd_a),
    .mem_rdata(mem_rdata_a),
    .dst_address(dst_address_a), .dst_data(dst_data_a), .dst_we(dst_we_a),
    .busy(busy_a), .done(done_a)
  );

  c6502_dma_arbiter #(.DMA_REG(16'h4014), .LEN(256)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .ce_in(ce_in),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we_b), .cpu_rd(cpu_rd),
    .cpu_in(cpu_in_b), .cpu_ce(cpu_ce_b),
    .mem_address(mem_address_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b),
    .mem_rdata(mem_rdata_b),
    .dst_address(dst_address_b), .dst_data(dst_data_b), .dst_we(dst_we_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic trigger_a(input logic [7:0] page);
    cpu_address = 16'h4014;
    cpu_out     = page;
    cpu_we_a    = 1'b1;
    #1;
    check_eq("trig_mem_we", 32'(mem_we_a), 32'h0);
    check_eq("trig_busy", 32'(busy_a), 32'h0);
    tick();
    cpu_we_a = 1'b0;
  endtask

  initial begin
    int errs;
    int stalls;
    logic [7:0] last_dst;
    logic [7:0] idx;

    reset_n = 1'b0; ce_in = 1'b1; cpu_address = '0; cpu_out = '0;
    cpu_we_a = 1'b0; cpu_we_b = 1'b0; cpu_rd = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_done", 32'(done_a), 32'h0);
    check_eq("rst_dst_we", 32'(dst_we_a), 32'h0);
    check_eq("rst_dst_addr", 32'(dst_address_a), 32'h0);
    check_eq("rst_dst_data", 32'(dst_data_a), 32'h0);
    check_eq("rst_cpu_ce", 32'(cpu_ce_a), 32'h1);
    ce_in = 1'b0;
    #1;
    check_eq("rst_cpu_ce_off", 32'(cpu_ce_a), 32'h0);
    ce_in   = 1'b1;
    reset_n = 1'b1;
    tick();

    // Passthrough write
    cpu_address = 16'h0300; cpu_out = 8'h5A; cpu_we_a = 1'b1;
    #1;
    check_eq("pt_mem_we", 32'(mem_we_a), 32'h1);
    check_eq("pt_mem_addr", 32'(mem_address_a), 32'h0300);
    check_eq("pt_mem_wdata", 32'(mem_wdata_a), 32'h5A);
    check_eq("pt_cpu_ce", 32'(cpu_ce_a), 32'h1);
    check_eq("pt_busy", 32'(busy_a), 32'h0);
    check_eq("pt_b_wdata", 32'(mem_wdata_b), 32'h5A);
    check_eq("pt_b_mem_we", 32'(mem_we_b), 32'h0);
    tick();

    // Read of DMA_REG passes through
    cpu_we_a = 1'b0; cpu_rd = 1'b1; cpu_address = 16'h4014;
    #1;
    check_eq("rd_mem_rd", 32'(mem_rd_a), 32'h1);
    check_eq("rd_mem_addr", 32'(mem_address_a), 32'h4014);
    check_eq("rd_mem_we", 32'(mem_we_a), 32'h0);
    check_eq("rd_cpu_in", 32'(cpu_in_a), 32'h77);
    tick();
    cpu_rd = 1'b0;
    #1;
    check_eq("rd_no_dma", 32'(busy_a), 32'h0);

    // Write of DMA_REG while ce_in=0 does not trigger
    ce_in = 1'b0; cpu_address = 16'h4014; cpu_out = 8'h02; cpu_we_a = 1'b1;
    #1;
    check_eq("ce0_mem_we", 32'(mem_we_a), 32'h0);
    tick();
    cpu_we_a = 1'b0; ce_in = 1'b1;
    #1;
    check_eq("ce0_no_dma", 32'(busy_a), 32'h0);

    // LEN=4 transfer from page 0x02; stray CPU writes during the stall must be ignored
    trigger_a(8'h02);
    cpu_address = 16'h0300; cpu_we_a = 1'b1; cpu_out = 8'hCC;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check_eq("x_cpu_ce", 32'(cpu_ce_a), 32'h0);
      check_eq("x_busy", 32'(busy_a), 32'h1);
      check_eq("x_mem_we", 32'(mem_we_a), 32'h0);
      if (k % 2 == 1) begin
        check_eq("x_src_addr", 32'(mem_address_a), 32'h0200 + 32'((k - 1) / 2));
        check_eq("x_dst_we_rd", 32'(dst_we_a), 32'h0);
      end else begin
        check_eq("x_dst_we", 32'(dst_we_a), 32'h1);
        check_eq("x_dst_addr", 32'(dst_address_a), 32'(k / 2 - 1));
        check_eq("x_dst_data", 32'(dst_data_a), 32'(src_a(k / 2 - 1)));
      end
      if (k == 8) cpu_we_a = 1'b0;
      tick();
    end
    #1;
    check_eq("x_done", 32'(done_a), 32'h1);
    check_eq("x_cpu_ce_back", 32'(cpu_ce_a), 32'h1);
    check_eq("x_busy_end", 32'(busy_a), 32'h0);
    tick();
    #1;
    check_eq("x_done_clr", 32'(done_a), 32'h0);

    // ce_in toggling 1,0,1,0 during the transfer
    trigger_a(8'h02);
    for (int k = 1; k <= 15; k++) begin
      ce_in = (k % 2 == 1);
      #1;
      check_eq("ce_busy", 32'(busy_a), 32'h1);
      if (!ce_in) check_eq("ce_dst_we_low", 32'(dst_we_a), 32'h0);
      if (k % 4 == 2) check_eq("ce_cnt_held", 32'(dst_address_a), 32'((k - 2) / 4));
      if (k % 4 == 3) begin
        check_eq("ce_dst_we", 32'(dst_we_a), 32'h1);
        check_eq("ce_dst_addr", 32'(dst_address_a), 32'((k - 3) / 4));
        check_eq("ce_dst_data", 32'(dst_data_a), 32'(src_a((k - 3) / 4)));
      end
      tick();
    end
    ce_in = 1'b0;
    #1;
    check_eq("ce_end_busy", 32'(busy_a), 32'h0);
    check_eq("ce_end_done", 32'(done_a), 32'h1);
    tick();
    ce_in = 1'b1;
    #1;
    check_eq("ce_end_cpu_ce", 32'(cpu_ce_a), 32'h1);
    tick();
    #1;
    check_eq("ce_done_clr", 32'(done_a), 32'h0);

    // Reset on the third transfer cycle
    trigger_a(8'h02);
    #1;
    check_eq("ra_c1_dst_we", 32'(dst_we_a), 32'h0);
    tick();
    #1;
    check_eq("ra_c2_dst_we", 32'(dst_we_a), 32'h1);
    check_eq("ra_c2_dst_addr", 32'(dst_address_a), 32'h0);
    check_eq("ra_c2_dst_data", 32'(dst_data_a), 32'h11);
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("ra_c3_dst_we", 32'(dst_we_a), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("ra_busy", 32'(busy_a), 32'h0);
    check_eq("ra_dst_we", 32'(dst_we_a), 32'h0);
    check_eq("ra_cpu_ce", 32'(cpu_ce_a), 32'h1);
    check_eq("ra_done", 32'(done_a), 32'h0);
    tick();
    #1;
    check_eq("ra_done2", 32'(done_a), 32'h0);

    // Reset asserted during a write cycle suppresses dst_we in that same cycle
    trigger_a(8'h02);
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("rw_dst_we", 32'(dst_we_a), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rw_busy", 32'(busy_a), 32'h0);

    // LEN=256 copy from page 0xFF
    cpu_address = 16'h4014; cpu_out = 8'hFF; cpu_we_b = 1'b1;
    #1;
    check_eq("b_trig_mem_we", 32'(mem_we_b), 32'h0);
    tick();
    cpu_we_b = 1'b0;
    errs = 0; stalls = 0; last_dst = 8'h00;
    for (int k = 1; k <= 512; k++) begin
      #1;
      if (cpu_ce_b === 1'b0 && busy_b === 1'b1) stalls++;
      if (k % 2 == 1) begin
        idx = 8'((k - 1) / 2);
        if (mem_address_b !== {8'hFF, idx} || mem_rd_b !== 1'b1 || dst_we_b !== 1'b0) errs++;
        if (k == 511) check_eq("b_cpu_in", 32'(cpu_in_b), 32'h5A);
      end else begin
        idx = 8'(k / 2 - 1);
        if (dst_we_b !== 1'b1 || dst_address_b !== idx || dst_data_b !== (idx ^ 8'hA5)) errs++;
        last_dst = dst_address_b;
      end
      tick();
    end
    #1;
    check_eq("b_errs", 32'(errs), 32'h0);
    check_eq("b_stalls", 32'(stalls), 32'd512);
    check_eq("b_last_dst", 32'(last_dst), 32'hFF);
    check_eq("b_done", 32'(done_b), 32'h1);
    check_eq("b_cpu_ce", 32'(cpu_ce_b), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
